// File: rtl/dpram_responder.sv
// Two-port 2**ADDR_W x DATA_W RAM responder: valid/ready requests per port, registered read-first responses.
// Optional DPRAM_RESP_INIT_CLEAR_EN adds an INIT state that zeroes the array after reset.
module dpram_responder #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              a_req_valid,
    output logic              a_req_ready,
    input  logic              a_req_we,
    input  logic [ADDR_W-1:0] a_req_addr,
    input  logic [DATA_W-1:0] a_req_wdata,
    output logic              a_rsp_valid,
    input  logic              a_rsp_ready,
    output logic [DATA_W-1:0] a_rsp_rdata,

    input  logic              b_req_valid,
    output logic              b_req_ready,
    input  logic              b_req_we,
    input  logic [ADDR_W-1:0] b_req_addr,
    input  logic [DATA_W-1:0] b_req_wdata,
    output logic              b_rsp_valid,
    input  logic              b_rsp_ready,
    output logic [DATA_W-1:0] b_rsp_rdata
);
    localparam int DEPTH = 1 << ADDR_W;

`ifdef DPRAM_RESP_INIT_CLEAR_EN
    typedef enum logic {INIT, RUN} state_t;
    localparam state_t RST_STATE = INIT;
`else
    typedef enum logic {RUN} state_t;
    localparam state_t RST_STATE = RUN;
`endif

    state_t state;
    state_t state_nxt;
    logic   run;
    logic   clr_we;

    logic [ADDR_W-1:0] clr_addr;
    logic [DATA_W-1:0] mem [DEPTH];

    logic collide;
    logic a_acc, a_wr, a_rd;
    logic b_acc, b_wr, b_rd;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RST_STATE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        run       = (state == RUN);
        clr_we    = 1'b0;
`ifdef DPRAM_RESP_INIT_CLEAR_EN
        if (state == INIT) begin
            clr_we = 1'b1;
            if (clr_addr == {ADDR_W{1'b1}}) begin
                state_nxt = RUN;
            end
        end
`endif
    end

`ifdef DPRAM_RESP_INIT_CLEAR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            clr_addr <= '0;
        end else if (clr_we) begin
            clr_addr <= clr_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
    end
`else
    assign clr_addr = '0;
`endif

    // Same-address write/write: A wins this cycle, B is held off and lands next.
    assign collide = a_req_valid & a_req_we & b_req_valid & b_req_we &
                     (a_req_addr == b_req_addr);

    assign a_req_ready = run & ~(a_rsp_valid & ~a_rsp_ready);
    assign b_req_ready = run & ~(b_rsp_valid & ~b_rsp_ready) & ~collide;

    assign a_acc = a_req_valid & a_req_ready;
    assign b_acc = b_req_valid & b_req_ready;
    assign a_wr  = a_acc & a_req_we;
    assign a_rd  = a_acc & ~a_req_we;
    assign b_wr  = b_acc & b_req_we;
    assign b_rd  = b_acc & ~b_req_we;

    // Accepted writes never share an address (collide blocks B), so the two ports never race.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (clr_we) begin
                mem[clr_addr] <= '0;
            end
            if (a_wr) begin
                mem[a_req_addr] <= a_req_wdata;
            end
            if (b_wr) begin
                mem[b_req_addr] <= b_req_wdata;
            end
        end
    end

    // Reads sample the array before this edge's writes land (read-first).
    always_ff @(posedge clk) begin
        if (rst) begin
            a_rsp_valid <= 1'b0;
            a_rsp_rdata <= '0;
        end else if (a_rd) begin
            a_rsp_valid <= 1'b1;
            a_rsp_rdata <= mem[a_req_addr];
        end else if (a_rsp_ready) begin
            a_rsp_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            b_rsp_valid <= 1'b0;
            b_rsp_rdata <= '0;
        end else if (b_rd) begin
            b_rsp_valid <= 1'b1;
            b_rsp_rdata <= mem[b_req_addr];
        end else if (b_rsp_ready) begin
            b_rsp_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_dpram_responder.sv
// Bench for dpram_responder: directed scenarios plus random two-port traffic against an array-level model.
module tb_dpram_responder;
    logic       clk = 1'b0;
    logic       rst;
    logic       a_req_valid, a_req_ready, a_req_we, a_rsp_valid, a_rsp_ready;
    logic [7:0] a_req_addr, a_req_wdata, a_rsp_rdata;
    logic       b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_rsp_ready;
    logic [7:0] b_req_addr, b_req_wdata, b_rsp_rdata;

    always #5 clk = ~clk;

    dpram_responder #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk(clk), .rst(rst),
        .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_we(a_req_we),
        .a_req_addr(a_req_addr), .a_req_wdata(a_req_wdata), .a_rsp_valid(a_rsp_valid),
        .a_rsp_ready(a_rsp_ready), .a_rsp_rdata(a_rsp_rdata),
        .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_we(b_req_we),
        .b_req_addr(b_req_addr), .b_req_wdata(b_req_wdata), .b_rsp_valid(b_rsp_valid),
        .b_rsp_ready(b_rsp_ready), .b_rsp_rdata(b_rsp_rdata)
    );

    typedef struct packed {
        logic       valid;
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic       rsp_ready;
    } req_t;

    int errors = 0;
    int checks = 0;

    // Reference model: array contents, which entries are defined, and the pending response per port.
    logic [7:0] mem_m [256];
    bit         known [256];
    bit         running;
    int         init_left;
    bit         ea_v, eb_v, ea_k, eb_k;
    logic [7:0] ea_d, eb_d;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic req_t rq(bit v, bit we, logic [7:0] addr, logic [7:0] wd, bit rr);
        req_t r;
        r.valid = v; r.we = we; r.addr = addr; r.wdata = wd; r.rsp_ready = rr;
        return r;
    endfunction

    function automatic req_t idle();
        return rq(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    endfunction

    function automatic req_t rnd_req();
        req_t r;
        r.valid     = ($urandom_range(0, 3) != 0);
        r.we        = $urandom_range(0, 1);
        r.addr      = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'(8'h50 + $urandom_range(0, 3));
        r.wdata     = 8'($urandom);
        r.rsp_ready = ($urandom_range(0, 3) != 0);
        return r;
    endfunction

    task automatic model_reset();
        ea_v = 0; eb_v = 0; ea_d = '0; eb_d = '0; ea_k = 1; eb_k = 1;
`ifdef DPRAM_RESP_INIT_CLEAR_EN
        running   = 0;
        init_left = 256;
        for (int i = 0; i < 256; i++) begin
            mem_m[i] = '0;
            known[i] = 1;
        end
`else
        running = 1;
`endif
    endtask

    // One clock: compare registered outputs, drive new inputs, compare ready, advance the model.
    task automatic step(input bit r, input req_t a, input req_t b);
        bit         coll, ra, rb, acc_a, acc_b, ka, kb;
        logic [7:0] old_a, old_b;
        @(negedge clk);
        chk("a_rsp_valid", a_rsp_valid, ea_v);
        chk("b_rsp_valid", b_rsp_valid, eb_v);
        if (ea_v && ea_k) chk("a_rsp_rdata", a_rsp_rdata, ea_d);
        if (eb_v && eb_k) chk("b_rsp_rdata", b_rsp_rdata, eb_d);
        rst = r;
        a_req_valid = a.valid; a_req_we = a.we; a_req_addr = a.addr;
        a_req_wdata = a.wdata; a_rsp_ready = a.rsp_ready;
        b_req_valid = b.valid; b_req_we = b.we; b_req_addr = b.addr;
        b_req_wdata = b.wdata; b_rsp_ready = b.rsp_ready;
        #1;
        coll = a.valid && a.we && b.valid && b.we && (a.addr == b.addr);
        ra   = running && !(ea_v && !a.rsp_ready);
        rb   = running && !(eb_v && !b.rsp_ready) && !coll;
        if (r) begin
            model_reset();
        end else begin
            chk("a_req_ready", a_req_ready, ra);
            chk("b_req_ready", b_req_ready, rb);
            acc_a = a.valid && ra;
            acc_b = b.valid && rb;
            old_a = mem_m[a.addr]; ka = known[a.addr];
            old_b = mem_m[b.addr]; kb = known[b.addr];
            if (acc_a && !a.we) begin
                ea_v = 1; ea_d = old_a; ea_k = ka;
            end else if (a.rsp_ready) begin
                ea_v = 0;
            end
            if (acc_b && !b.we) begin
                eb_v = 1; eb_d = old_b; eb_k = kb;
            end else if (b.rsp_ready) begin
                eb_v = 0;
            end
            if (acc_a && a.we) begin
                mem_m[a.addr] = a.wdata; known[a.addr] = 1;
            end
            if (acc_b && b.we) begin
                mem_m[b.addr] = b.wdata; known[b.addr] = 1;
            end
            if (!running) begin
                init_left--;
                if (init_left == 0) running = 1;
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem_m[i] = '0;
            known[i] = 0;
        end
        rst = 1'b1;
        a_req_valid = 0; a_req_we = 0; a_req_addr = '0; a_req_wdata = '0; a_rsp_ready = 1;
        b_req_valid = 0; b_req_we = 0; b_req_addr = '0; b_req_wdata = '0; b_rsp_ready = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_a_rsp_valid", a_rsp_valid, 1'b0);
        chk("rst_b_rsp_valid", b_rsp_valid, 1'b0);
        chk("rst_a_rsp_rdata", a_rsp_rdata, 8'h00);
        chk("rst_b_rsp_rdata", b_rsp_rdata, 8'h00);
        model_reset();

        while (!running) step(1'b0, idle(), idle());
`ifdef DPRAM_RESP_INIT_CLEAR_EN
        step(1'b0, rq(1, 0, 8'h15, 8'h00, 1), idle());
        step(1'b0, idle(), idle());
        chk("init_clear_rd15", a_rsp_rdata, 8'h00);
`endif

        // Single-port traffic
        step(1'b0, rq(1, 1, 8'h15, 8'hA1, 1), rq(1, 1, 8'h25, 8'hB2, 1));
        step(1'b0, rq(1, 0, 8'h15, 8'h00, 1), rq(1, 0, 8'h25, 8'h00, 1));
        step(1'b0, idle(), idle());
        chk("single_a_rdata", a_rsp_rdata, 8'hA1);
        chk("single_b_rdata", b_rsp_rdata, 8'hB2);

        // Write collision
        step(1'b0, rq(1, 1, 8'h30, 8'hC2, 1), rq(1, 1, 8'h30, 8'h2C, 1));
        chk("coll_b_ready_low", b_req_ready, 1'b0);
        step(1'b0, idle(), rq(1, 1, 8'h30, 8'h2C, 1));
        chk("coll_b_retry_ready", b_req_ready, 1'b1);
        step(1'b0, rq(1, 0, 8'h30, 8'h00, 1), rq(1, 0, 8'h30, 8'h00, 1));
        step(1'b0, idle(), idle());
        chk("coll_a_rd30", a_rsp_rdata, 8'h2C);
        chk("coll_b_rd30", b_rsp_rdata, 8'h2C);

        // Read-first on opposite ports
        step(1'b0, rq(1, 1, 8'h40, 8'h11, 1), idle());
        step(1'b0, rq(1, 1, 8'h40, 8'h99, 1), rq(1, 0, 8'h40, 8'h00, 1));
        step(1'b0, rq(1, 0, 8'h40, 8'h00, 1), idle());
        chk("rdfirst_b_old", b_rsp_rdata, 8'h11);
        step(1'b0, idle(), idle());
        chk("rdfirst_a_new", a_rsp_rdata, 8'h99);

        // Backpressure
        step(1'b0, rq(1, 0, 8'h15, 8'h00, 1), idle());
        for (int i = 0; i < 3; i++) begin
            step(1'b0, rq(1, 0, 8'h25, 8'h00, 0), idle());
            chk("bp_a_req_ready", a_req_ready, 1'b0);
            chk("bp_a_rsp_valid", a_rsp_valid, 1'b1);
            chk("bp_a_rsp_rdata", a_rsp_rdata, 8'hA1);
        end
        step(1'b0, idle(), idle());
        chk("bp_release_ready", a_req_ready, 1'b1);
        step(1'b0, idle(), idle());
        chk("bp_drained_valid", a_rsp_valid, 1'b0);

        // Back-to-back reads
        step(1'b0, rq(1, 0, 8'h15, 8'h00, 1), idle());
        step(1'b0, rq(1, 0, 8'h25, 8'h00, 1), idle());
        chk("b2b_first", a_rsp_rdata, 8'hA1);
        step(1'b0, idle(), idle());
        chk("b2b_second", a_rsp_rdata, 8'hB2);
        chk("b2b_second_valid", a_rsp_valid, 1'b1);

        // Reset while a response is pending
        step(1'b0, rq(1, 0, 8'h15, 8'h00, 0), idle());
        step(1'b0, idle(), idle());
        step(1'b1, rq(1, 1, 8'h15, 8'h77, 1), idle());
        step(1'b0, idle(), idle());
        chk("midrst_a_rsp_valid", a_rsp_valid, 1'b0);
        while (!running) step(1'b0, idle(), idle());
`ifdef DPRAM_RESP_INIT_CLEAR_EN
        step(1'b0, rq(1, 0, 8'h15, 8'h00, 1), idle());
        step(1'b0, idle(), idle());
        chk("reinit_rd15", a_rsp_rdata, 8'h00);
`else
        step(1'b0, rq(1, 0, 8'h15, 8'h00, 1), idle());
        step(1'b0, idle(), idle());
        chk("rst_write_dropped", a_rsp_rdata, 8'hA1);
`endif

        // Random two-port traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 99) == 0), rnd_req(), rnd_req());
        end
        step(1'b0, idle(), idle());
        step(1'b0, idle(), idle());

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
